pc_host_framer: RTL and testbench

//  Host-side counterpart of the FPGA core's PC-output packer. Accepts 35b PC_out words {route,code,data} from the core
//  and frames them into 32b words for the host USB block-read pipe. Home-routed words become one host word; other

---
 rtl/pc_host_pkg.sv | 34 +++
 rtl/pc_host_framer_if.sv | 13 +
 rtl/host_word_fifo.sv | 73 +++++++
 rtl/pc_host_framer.sv | 143 ++++++++++++++
 tb/tb_pc_host_framer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_host_pkg.sv
// Shared word formats, widths and FSM state type for the host-side PC word framer.
package pc_host_pkg;

    localparam int NPCcode  = 7;
    localparam int NPCdata  = 20;
    localparam int NPCroute = 8;
    localparam int NPCout   = NPCcode + NPCdata + NPCroute;

    localparam int HOST_W   = 32;
    localparam int HDR_FLAG = 31;
    localparam logic [HOST_W-1:0] HOST_NOP = 32'hFFFF_FFFF;

    typedef logic [HOST_W-1:0] host_word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        PAD     = 2'd2
    } fsm_state_t;

    function automatic host_word_t pack_home(input logic [NPCcode-1:0] code,
                                             input logic [NPCdata-1:0] data);
        return host_word_t'({code, data});
    endfunction

    function automatic host_word_t pack_hdr(input logic [NPCroute-1:0] route);
        host_word_t w;
        w = '0;
        w[HDR_FLAG] = 1'b1;
        w[NPCroute-1:0] = route;
        return w;
    endfunction

endpackage

// File: rtl/pc_host_framer_if.sv
// PC_out word channel from the core into the host framer.
// A word transfers on a rising clock edge where v and a are both high; d is sampled only then.
interface pc_host_framer_if;
    import pc_host_pkg::*;

    logic [NPCout-1:0] d;
    logic              v;
    logic              a;

    modport master (output d, output v, input a);
    modport slave  (input d, input v, output a);

endinterface

// File: rtl/host_word_fifo.sv
// Synchronous word FIFO with occupancy count, registered read data and a registered fill threshold flag.
module host_word_fifo #(
    parameter int W = 32,
    parameter int D = 64,
    parameter int THRESH = 16,
    parameter logic [W-1:0] EMPTY_WORD = '1,
    localparam int AW = $clog2(D),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    output logic [W-1:0]  rd_data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          thresh_o
);

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic          thresh_q, thresh_d;
    logic          do_wr, do_rd;

    assign full_o  = (count_q == CW'(D));
    assign empty_o = (count_q == '0);
    assign do_wr   = wr_en_i & ~full_o;
    assign do_rd   = rd_en_i & ~empty_o;

    // A pop on an empty FIFO still updates the output register, with EMPTY_WORD.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + AW'(do_wr);
        rd_ptr_d  = rd_ptr_q + AW'(do_rd);
        count_d   = count_q + CW'(do_wr) - CW'(do_rd);
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = do_rd ? mem[rd_ptr_q] : EMPTY_WORD;
        end
        thresh_d  = (count_d >= CW'(THRESH));
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= EMPTY_WORD;
            thresh_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            thresh_q  <= thresh_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign count_o   = count_q;
    assign thresh_o  = thresh_q;

endmodule

// File: rtl/pc_host_framer.sv
// Frames 35b PC_out words into 32b host words; routed words get a header, partial blocks are NOP-padded after a timeout.
module pc_host_framer
    import pc_host_pkg::*;
#(
    parameter logic [NPCroute-1:0] GO_HOME_rt = 8'hE0,
    parameter int BLOCK_WORDS  = 16,
    parameter int FIFO_D       = 64,
    parameter int FLUSH_CYCLES = 1024,
    localparam int PW = $clog2(BLOCK_WORDS),
    localparam int CW = $clog2(FIFO_D) + 1,
    localparam int TW = $clog2(FLUSH_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    pc_host_framer_if.slave        PC_out,
    input  logic                   host_rd,
    output host_word_t             host_dout,
    output logic                   host_blk_rdy,
    output logic                   underrun,
    output fsm_state_t             dbg_state_o,
    output logic [PW-1:0]          dbg_wr_phase_o,
    output logic [CW-1:0]          dbg_count_o
);

    fsm_state_t                   state_q, state_d;
    logic [PW-1:0]                wr_phase_q, wr_phase_d;
    logic [TW-1:0]                timer_q, timer_d;
    logic [NPCcode+NPCdata-1:0]   pay_q, pay_d;
    logic                         underrun_q, underrun_d;

    logic                         in_ack, hs, wr_en, free2;
    host_word_t                   wr_data;
    logic [CW-1:0]                count;
    logic                         fifo_full, fifo_empty;
    logic [NPCroute-1:0]          in_route;
    logic [NPCcode-1:0]           in_code;
    logic [NPCdata-1:0]           in_data;

    assign in_route = PC_out.d[NPCout-1 -: NPCroute];
    assign in_code  = PC_out.d[NPCcode+NPCdata-1 -: NPCcode];
    assign in_data  = PC_out.d[NPCdata-1:0];
    // Two free slots guarantee a header and its payload always land back to back.
    assign free2    = (count <= CW'(FIFO_D - 2));

    always_comb begin
        state_d    = state_q;
        wr_phase_d = wr_phase_q;
        timer_d    = timer_q;
        pay_d      = pay_q;
        in_ack     = 1'b0;
        hs         = 1'b0;
        wr_en      = 1'b0;
        wr_data    = HOST_NOP;
        underrun_d = underrun_q | (host_rd & fifo_empty);

        case (state_q)
            IDLE: begin
                in_ack = free2;
                hs     = PC_out.v & free2;
                if (hs) begin
                    wr_en   = 1'b1;
                    timer_d = '0;
                    if (in_route == GO_HOME_rt) begin
                        wr_data = pack_home(in_code, in_data);
                    end else begin
                        wr_data = pack_hdr(in_route);
                        pay_d   = {in_code, in_data};
                        state_d = PAYLOAD;
                    end
                end else if (wr_phase_q == '0) begin
                    timer_d = '0;
                end else if (timer_q == TW'(FLUSH_CYCLES - 1)) begin
                    state_d = PAD;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            PAYLOAD: begin
                wr_en   = 1'b1;
                wr_data = pack_home(pay_q[NPCcode+NPCdata-1 -: NPCcode], pay_q[NPCdata-1:0]);
                timer_d = '0;
                state_d = IDLE;
            end
            PAD: begin
                if (!fifo_full) begin
                    wr_en = 1'b1;
                    if (wr_phase_q == PW'(BLOCK_WORDS - 1)) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wr_en) begin
            wr_phase_d = wr_phase_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_phase_q <= '0;
            timer_q    <= '0;
            pay_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_phase_q <= wr_phase_d;
            timer_q    <= timer_d;
            pay_q      <= pay_d;
            underrun_q <= underrun_d;
        end
    end

    host_word_fifo #(
        .W          (HOST_W),
        .D          (FIFO_D),
        .THRESH     (BLOCK_WORDS),
        .EMPTY_WORD (HOST_NOP)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (host_rd),
        .rd_data_o (host_dout),
        .count_o   (count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .thresh_o  (host_blk_rdy)
    );

    assign PC_out.a       = in_ack & ~reset;
    assign underrun       = underrun_q;
    assign dbg_state_o    = state_q;
    assign dbg_wr_phase_o = wr_phase_q;
    assign dbg_count_o    = count;

endmodule

// File: tb/tb_pc_host_framer.sv
// Bench for pc_host_framer: hand-derived vector table, flush/back-pressure/reset sequences, random stream vs. model.
module tb_pc_host_framer;
    import pc_host_pkg::*;

    localparam int BW = 16;
    localparam int FD = 64;
    localparam int FC = 1024;
    localparam logic [31:0] NOP_W = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        host_rd = 1'b0;
    logic [31:0] host_dout;
    logic        host_blk_rdy, underrun;
    fsm_state_t  dbg_state;
    logic [3:0]  dbg_phase;
    logic [6:0]  dbg_count;

    pc_host_framer_if pc_if ();

    pc_host_framer #(
        .GO_HOME_rt   (8'hE0),
        .BLOCK_WORDS  (BW),
        .FIFO_D       (FD),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .PC_out         (pc_if),
        .host_rd        (host_rd),
        .host_dout      (host_dout),
        .host_blk_rdy   (host_blk_rdy),
        .underrun       (underrun),
        .dbg_state_o    (dbg_state),
        .dbg_wr_phase_o (dbg_phase),
        .dbg_count_o    (dbg_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic last_hdr;

    typedef struct {
        logic [7:0]  route;
        logic [6:0]  code;
        logic [19:0] data;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;
    vec_t vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] home_word(input logic [6:0] c, input logic [19:0] d);
        return (32'(c) << 20) + 32'(d);
    endfunction

    function automatic logic [31:0] hdr_word(input logic [7:0] r);
        return 32'h8000_0000 + 32'(r);
    endfunction

    task automatic push_frame(input logic [7:0] r, input logic [6:0] c, input logic [19:0] d);
        if (r == 8'hE0) begin
            exp_q.push_back(home_word(c, d));
        end else begin
            exp_q.push_back(hdr_word(r));
            exp_q.push_back(home_word(c, d));
        end
    endtask

    function automatic logic [31:0] pop_exp();
        if (exp_q.size() == 0) return 32'hDEAD_0000;
        return exp_q.pop_front();
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive_cycle(input logic v, input logic [34:0] d, input logic rd, output logic acc);
        pc_if.v = v;
        pc_if.d = d;
        host_rd = rd;
        #1;
        acc = v & pc_if.a;
        @(negedge clk);
    endtask

    task automatic read_word(output logic [31:0] w);
        host_rd = 1'b1;
        @(negedge clk);
        host_rd = 1'b0;
        w = host_dout;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        pc_if.v = 1'b0;
        pc_if.d = '0;
        host_rd = 1'b0;
        #1;
        check("rst_ack", 32'(pc_if.a), 0);
        check("rst_dout", host_dout, NOP_W);
        check("rst_blk", 32'(host_blk_rdy), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_count", 32'(dbg_count), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_phase", 32'(dbg_phase), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        last_hdr = 1'b0;
    endtask

    task automatic check_stream_word(input logic [31:0] w);
        if (w == NOP_W) begin
            if (last_hdr) begin
                n_checks++;
                n_fail++;
                $display("FAIL hdr_split: got NOP after header, expected payload at %0t", $time);
                last_hdr = 1'b0;
            end
        end else begin
            check("stream_word", w, pop_exp());
            last_hdr = w[31];
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic        acc;
        logic [31:0] w;
        logic [34:0] wd;
        int          idx, extra, accepted;
        logic [7:0]  r;
        logic [6:0]  c;
        logic [19:0] dd;
        logic        v, rd, seen_stall;

        vt[0] = '{8'hE0, 7'h05, 20'h12345, 1, 32'h0051_2345, 32'h0};
        vt[1] = '{8'h03, 7'h01, 20'h00001, 2, 32'h8000_0003, 32'h0010_0001};
        vt[2] = '{8'hE0, 7'h7F, 20'hFFFFF, 1, 32'h07FF_FFFF, 32'h0};
        vt[3] = '{8'hE1, 7'h00, 20'h00000, 2, 32'h8000_00E1, 32'h0000_0000};
        vt[4] = '{8'h00, 7'h2A, 20'hABCDE, 2, 32'h8000_0000, 32'h02AA_BCDE};
        vt[5] = '{8'hDF, 7'h40, 20'h80000, 2, 32'h8000_00DF, 32'h0408_0000};
        vt[6] = '{8'hE0, 7'h00, 20'h00000, 1, 32'h0000_0000, 32'h0};

        pc_if.v = 1'b0;
        pc_if.d = '0;
        last_hdr = 1'b0;
        @(negedge clk);
        do_reset();

        // Single-word framing vectors, each from an empty FIFO.
        for (int i = 0; i < 7; i++) begin
            drive_cycle(1'b1, {vt[i].route, vt[i].code, vt[i].data}, 1'b0, acc);
            check("tbl_ack", 32'(acc), 1);
            pc_if.v = 1'b0;
            #1;
            check("tbl_cnt_1cyc", 32'(dbg_count), 1);
            if (vt[i].n == 2) begin
                check("tbl_payload_state", 32'(dbg_state), 32'(PAYLOAD));
                check("tbl_payload_ack", 32'(pc_if.a), 0);
            end
            @(negedge clk);
            check("tbl_cnt", 32'(dbg_count), 32'(vt[i].n));
            read_word(w);
            check("tbl_w0", w, vt[i].w0);
            if (vt[i].n == 2) begin
                read_word(w);
                check("tbl_w1", w, vt[i].w1);
            end
        end

        // Flush: three home words, then idle until padding completes the block.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, {8'hE0, 7'(i + 1), 20'(i * 3 + 7)}, 1'b0, acc);
            check("t3_acc", 32'(acc), 1);
            exp_q.push_back(home_word(7'(i + 1), 20'(i * 3 + 7)));
        end
        repeat (1000) drive_cycle(1'b0, '0, 1'b0, acc);
        check("t3_no_early_pad", 32'(dbg_count), 3);
        check("t3_phase_mid", 32'(dbg_phase), 3);
        repeat (100) drive_cycle(1'b0, '0, 1'b0, acc);
        check("t3_count", 32'(dbg_count), BW);
        check("t3_blk", 32'(host_blk_rdy), 1);
        check("t3_phase", 32'(dbg_phase), 0);
        check("t3_state", 32'(dbg_state), 32'(IDLE));
        for (int k = 0; k < BW; k++) begin
            read_word(w);
            if (k < 3) check("t3_data", w, pop_exp());
            else check("t3_nop", w, NOP_W);
        end
        check("t3_blk_after", 32'(host_blk_rdy), 0);

        // Back-pressure: host never reads while home words stream in.
        do_reset();
        idx = 0;
        seen_stall = 1'b0;
        wd = '0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            wd = {8'hE0, 7'(idx % 128), 20'(idx * 1237 + 5)};
            drive_cycle(1'b1, wd, 1'b0, acc);
            if (acc) begin
                exp_q.push_back(home_word(7'(idx % 128), 20'(idx * 1237 + 5)));
                idx++;
            end else if (!seen_stall) begin
                seen_stall = 1'b1;
                check("t4_stall_count", 32'(dbg_count), FD - 1);
            end
        end
        check("t4_accepted", idx, FD - 1);
        extra = 0;
        repeat (FC + 80) begin
            drive_cycle(1'b1, wd, 1'b0, acc);
            if (acc) extra++;
        end
        check("t4_no_extra_accept", extra, 0);
        check("t4_full_count", 32'(dbg_count), FD);
        check("t4_blk", 32'(host_blk_rdy), 1);
        pc_if.v = 1'b0;
        for (int k = 0; k < FD; k++) begin
            read_word(w);
            if (k < FD - 1) check("t4_order", w, pop_exp());
            else check("t4_pad_nop", w, NOP_W);
        end
        check("t4_empty", 32'(dbg_count), 0);
        check("t4_no_underrun", 32'(underrun), 0);

        // Underrun, then reset in the middle of a routed pair.
        do_reset();
        read_word(w);
        check("t5_empty_dout", w, NOP_W);
        check("t5_underrun", 32'(underrun), 1);
        check("t5_empty_count", 32'(dbg_count), 0);
        drive_cycle(1'b1, {8'h03, 7'h01, 20'h00001}, 1'b0, acc);
        check("t5_hdr_acc", 32'(acc), 1);
        check("t5_in_payload", 32'(dbg_state), 32'(PAYLOAD));
        do_reset();
        drive_cycle(1'b1, {8'hE0, 7'h33, 20'hABCDE}, 1'b0, acc);
        check("t5_post_acc", 32'(acc), 1);
        pc_if.v = 1'b0;
        check("t5_post_phase", 32'(dbg_phase), 1);
        read_word(w);
        check("t5_post_word", w, home_word(7'h33, 20'hABCDE));
        check("t5_post_count", 32'(dbg_count), 0);

        // Random stream against the framing model.
        do_reset();
        accepted = 0;
        for (int cyc = 0; cyc < 40000 && accepted < 10000; cyc++) begin
            r  = ($urandom_range(0, 1) == 1) ? 8'hE0 : 8'($urandom_range(0, 255));
            c  = 7'($urandom_range(0, 127));
            dd = 20'($urandom_range(0, 20'hFFFFF));
            v  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 3) != 0);
            drive_cycle(v, {r, c, dd}, rd, acc);
            if (acc) begin
                push_frame(r, c, dd);
                accepted++;
            end
            if (rd) check_stream_word(host_dout);
        end
        check("t6_accepted", 32'(accepted), 10000);
        repeat (FC + 40) drive_cycle(1'b0, '0, 1'b0, acc);
        for (int k = 0; k < FD; k++) begin
            drive_cycle(1'b0, '0, 1'b1, acc);
            check_stream_word(host_dout);
        end
        check("t6_all_delivered", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
